// File: rtl/simeck_pkg.sv
// simeck_pkg: widths, constants, payload structs, round function and FSM states
// shared by the Simeck32/64 decrypt core and its key schedule.
`timescale 1ns/1ps
package simeck_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BLOCK_W    = 2 * WORD_W;
  localparam int unsigned KEY_W      = 4 * WORD_W;
  localparam int unsigned ROUNDS_MAX = 32;
  localparam int unsigned RND_W      = $clog2(ROUNDS_MAX);
  localparam int unsigned LFSR_W     = 5;

  localparam logic [WORD_W-1:0] C_CONST   = 16'hFFFC;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b11111;

  typedef logic [WORD_W-1:0] word_t;

  // Block payload {L,R}, L in the upper half
  typedef struct packed {
    word_t l;
    word_t r;
  } block_t;

  // Master key {t2,t1,t0,k0}, k0 in the lowest word
  typedef struct packed {
    word_t t2;
    word_t t1;
    word_t t0;
    word_t k0;
  } key_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    DECRYPT = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Simeck round function: (x & rotl(x,5)) ^ rotl(x,1)
  function automatic word_t f(input word_t x);
    return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
  endfunction

endpackage

// File: rtl/simeck_keysched.sv
// simeck_keysched: Simeck32/64 key schedule. Holds the {t2,t1,t0,k} shift
// register and the z-sequence LFSR, and writes one round key per step into a
// ROUNDS x 16 store that the decrypt datapath reads combinationally.
`timescale 1ns/1ps
module simeck_keysched
  import simeck_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  key_t             i_key,
  input  logic             i_step,
  input  logic [RND_W-1:0] i_waddr,
  input  logic [RND_W-1:0] i_raddr,
  output word_t            o_rkey_c
);

  logic [LFSR_W-1:0] r_lfsr;
  word_t             r_k;
  word_t             r_t0;
  word_t             r_t1;
  word_t             r_t2;
  word_t             r_store [ROUNDS];
  word_t             w_t_new;

  // Newest t word: k_i ^ f(t_i) ^ C ^ z_i, z_i being the LFSR output bit
  assign w_t_new = r_k ^ f(r_t0) ^ C_CONST ^ WORD_W'(r_lfsr[0]);

  // Schedule shift register and LFSR: loaded on accept, advanced once per EXPAND cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k    <= '0;
      r_t0   <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (i_load) begin
      r_k    <= i_key.k0;
      r_t0   <= i_key.t0;
      r_t1   <= i_key.t1;
      r_t2   <= i_key.t2;
      r_lfsr <= LFSR_SEED;
    end else if (i_step) begin
      r_k    <= r_t0;
      r_t0   <= r_t1;
      r_t1   <= r_t2;
      r_t2   <= w_t_new;
      r_lfsr <= {r_lfsr[2] ^ r_lfsr[0], r_lfsr[LFSR_W-1:1]};
    end
  end

  // Round-key store: written only during EXPAND, deliberately left unreset
  always_ff @(posedge clk) begin
    if (i_step) begin
      r_store[i_waddr] <= r_k;
    end
  end

  assign o_rkey_c = r_store[i_raddr];

endmodule

// File: rtl/simeck_decrypt_core.sv
// simeck_decrypt_core: iterative Simeck32/64 decryption. Each block expands
// its key into the round-key store (EXPAND), then runs the rounds in reverse
// key order (DECRYPT) and holds the plaintext in DONE until taken.
// Optional build macro SIMECK_KEY_CACHE_EN: remember the last fully expanded
// key and skip EXPAND when the next block reuses it.
`timescale 1ns/1ps
module simeck_decrypt_core
  import simeck_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] ct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] pt,
  output logic               busy
);

  localparam logic [RND_W-1:0] CNT_LAST = RND_W'(ROUNDS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [RND_W-1:0] r_cnt;
  word_t            r_l;
  word_t            r_r;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;
  logic             w_cache_hit;
  logic             w_cnt_last;
  logic [RND_W-1:0] w_raddr;
  word_t            w_rkey;
  block_t           w_ct;

  assign w_ct       = block_t'(ct);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_raddr    = CNT_LAST - r_cnt;

`ifdef SIMECK_KEY_CACHE_EN
  logic [KEY_W-1:0] r_cache_key;
  logic             r_cache_vld;

  assign w_cache_hit = r_cache_vld && (key == r_cache_key);

  // Cache tracks the key whose schedule is complete in the store; invalid while expanding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
    end else if (w_accept && !w_cache_hit) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= key;
    end else if ((r_state == EXPAND) && w_cnt_last) begin
      r_cache_vld <= 1'b1;
    end
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  // Next-state decode; in_valid is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_cache_hit ? DECRYPT : EXPAND;
        end
      end
      EXPAND:  if (w_cnt_last) w_state_nxt = DECRYPT;
      DECRYPT: if (w_cnt_last) w_state_nxt = DONE;
      DONE:    if (out_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with registered handshake/status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt == EXPAND) || (w_state_nxt == DECRYPT);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Round counter: counts within EXPAND/DECRYPT, restarts at every phase change
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == EXPAND) || (r_state == DECRYPT)) begin
      r_cnt <= r_cnt + RND_W'(1);
    end
  end

  // Block halves: capture ciphertext on accept, one inverse round per DECRYPT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_l <= '0;
      r_r <= '0;
    end else if (w_accept) begin
      r_l <= w_ct.l;
      r_r <= w_ct.r;
    end else if (r_state == DECRYPT) begin
      r_l <= r_r;
      r_r <= r_l ^ f(r_r) ^ w_rkey;
    end
  end

  simeck_keysched #(
    .ROUNDS (ROUNDS)
  ) u_keysched (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept && !w_cache_hit),
    .i_key    (key_t'(key)),
    .i_step   (r_state == EXPAND),
    .i_waddr  (r_cnt),
    .i_raddr  (w_raddr),
    .o_rkey_c (w_rkey)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign pt        = {r_l, r_r};

endmodule

// File: tb/tb_simeck_decrypt_core.sv
// tb_simeck_decrypt_core: randomized bench for simeck_decrypt_core against a
// word-level Simeck32/64 encryption model; also models the optional key cache
// when SIMECK_KEY_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_simeck_decrypt_core;

  localparam int unsigned ROUNDS = 32;
  localparam int unsigned N_RAND = 1000;
`ifdef SIMECK_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] key       = '0;
  logic [31:0] ct        = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] pt;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int unsigned cyc       = 0;
  int unsigned acc_cyc   = 0;
  logic [63:0] cache_key = '0;
  bit          cache_vld = 1'b0;

  simeck_decrypt_core #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .ct        (ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference model: word sequence w[i] with k_i = w[i], t_i = w[i+1]
  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] fm(input logic [15:0] x);
    return (x & rotl(x, 5)) ^ rotl(x, 1);
  endfunction

  function automatic logic [31:0] model_encrypt(input logic [63:0] k, input logic [31:0] p);
    logic [15:0] w [0:ROUNDS+3];
    logic [31:0] zseq;
    logic [15:0] l, r, nl;
    zseq = 32'h9A42BB1F;
    for (int j = 0; j < 4; j++) w[j] = k[16*j +: 16];
    for (int i = 0; i < ROUNDS; i++) w[i+4] = w[i] ^ fm(w[i+1]) ^ 16'hFFFC ^ {15'd0, zseq[i]};
    l = p[31:16];
    r = p[15:0];
    for (int i = 0; i < ROUNDS; i++) begin
      nl = r ^ fm(l) ^ w[i];
      r  = l;
      l  = nl;
    end
    return {l, r};
  endfunction

  function automatic int unsigned expected_latency(input logic [63:0] k);
    if (CACHE_ON && cache_vld && (k == cache_key)) return ROUNDS + 1;
    return 2 * ROUNDS + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block and return just after the accept edge; inputs are scrambled afterwards
  task automatic accept(input logic [63:0] k, input logic [31:0] c);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    key      = k;
    ct       = c;
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    key      = {$urandom, $urandom};
    ct       = $urandom;
  endtask

  // Latency counts the accept cycle as cycle 1
  task automatic wait_done(output int unsigned lat);
    while (!out_valid && (cyc - acc_cyc) < 400) tick();
    if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
    lat = cyc - acc_cyc + 1;
  endtask

  // Take the result while also offering a new block that must not be accepted
  task automatic release_out();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("xfer_valid_drop", 64'(out_valid), 64'd0);
    check("xfer_ready_rise", 64'(in_ready), 64'd1);
    check("xfer_not_busy", 64'(busy), 64'd0);
  endtask

  task automatic hold_out(input int hold, input logic [31:0] p);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_pt", 64'(pt), 64'(p));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic run_block(input logic [63:0] k, input logic [31:0] p, input int hold);
    int unsigned lat;
    int unsigned exp_lat;
    exp_lat = expected_latency(k);
    accept(k, model_encrypt(k, p));
    wait_done(lat);
    check("latency", 64'(lat), 64'(exp_lat));
    check("pt", 64'(pt), 64'(p));
    hold_out(hold, p);
    release_out();
    cache_key = k;
    cache_vld = 1'b1;
  endtask

  initial begin
    logic [63:0]  k1, k2, kr, prev_k;
    logic [31:0]  p1, pr;
    int unsigned  lat;
    bit           seen;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pt", 64'(pt), 64'd0);
    reset = 1'b0;
    tick();

    // Published vector, then a 10-cycle stall of the consumer
    accept(64'h1918111009080100, 32'h770d2c76);
    check("kat_busy", 64'(busy), 64'd1);
    check("kat_in_ready_low", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("kat_latency", 64'(lat), 64'(2 * ROUNDS + 1));
    check("kat_pt", 64'(pt), 64'h65656877);
    hold_out(10, 32'h65656877);
    release_out();
    cache_key = 64'h1918111009080100;
    cache_vld = 1'b1;

    // New data offered during DECRYPT must be ignored
    k1 = {$urandom, $urandom};
    p1 = $urandom;
    k2 = {$urandom, $urandom};
    accept(k1, model_encrypt(k1, p1));
    repeat (ROUNDS + 8) tick();
    in_valid = 1'b1;
    key      = k2;
    ct       = $urandom;
    repeat (3) tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("ign_latency", 64'(lat), 64'(2 * ROUNDS + 1));
    check("ign_pt", 64'(pt), 64'(p1));
    release_out();
    cache_key = k1;
    cache_vld = 1'b1;

    // Same key back-to-back, then a changed key
    run_block(k2, $urandom, 0);
    run_block(k2, $urandom, 1);
    run_block(k1, $urandom, 0);

    // Abort with reset 40 cycles after accept
    kr = {$urandom, $urandom};
    pr = $urandom;
    accept(kr, model_encrypt(kr, pr));
    seen = 1'b0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    reset = 1'b1;
    tick();
    check("abort_rst_in_ready", 64'(in_ready), 64'd1);
    check("abort_rst_valid", 64'(out_valid), 64'd0);
    check("abort_rst_busy", 64'(busy), 64'd0);
    check("abort_rst_pt", 64'(pt), 64'd0);
    tick();
    reset = 1'b0;
    cache_vld = 1'b0;
    tick();
    check("abort_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 64'(seen), 64'd0);

    // Key that was cached before reset must expand again
    run_block(k1, $urandom, 0);

    // Random vectors, occasionally reusing the previous key
    prev_k = k1;
    for (int n = 0; n < N_RAND; n++) begin
      if ($urandom_range(0, 7) == 0) k1 = prev_k;
      else k1 = {$urandom, $urandom};
      run_block(k1, $urandom, int'($urandom_range(0, 2)));
      prev_k = k1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simeck_decrypt_core.md
SIMECK_DECRYPT_CORE -- requirements
Module: simeck_decrypt_core

Interface
REQ-001 Parameter ROUNDS, default 32: number of Simeck32/64 rounds; legal range 1..32.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  ciphertext and key are valid.
REQ-005 in_ready  out  1  core can accept a block; high only in IDLE.
REQ-006 key  in  64  master key {t2,t1,t0,k0}; k0 = key[15:0].
REQ-007 ct  in  32  ciphertext {L,R}; L = ct[31:16].
REQ-008 out_valid  out  1  plaintext is valid.
REQ-009 out_ready  in  1  consumer accepts the plaintext.
REQ-010 pt  out  32  plaintext {L,R}.
REQ-011 busy  out  1  high in EXPAND or DECRYPT.

Function
REQ-012 The core SHALL accept a block on a rising edge with in_valid=1 and in_ready=1, and SHALL register key and ct on that edge.
REQ-013 f(x) SHALL be (x & rotl(x,5)) ^ rotl(x,1) on 16-bit words.
REQ-014 EXPAND SHALL take ROUNDS cycles and write one round key per cycle, k_0..k_{ROUNDS-1}, into a ROUNDS x 16 key store.
REQ-015 Key schedule: k_{i+1}=t_i; t_{i+3}=k_i ^ f(t_i) ^ 16'hFFFC ^ z_i.
REQ-016 z_i SHALL come from a 5-bit LFSR, polynomial x^5+x^2+1, seed 5'b11111, reseeded at each EXPAND entry.
REQ-017 DECRYPT SHALL take ROUNDS cycles using keys k_{ROUNDS-1} down to k_0, one key per cycle.
REQ-018 Each DECRYPT cycle SHALL compute (L,R) <- (R, L ^ f(R) ^ k_i).
REQ-019 FSM states: IDLE -> EXPAND on accept; EXPAND -> DECRYPT after the last key is written; DECRYPT -> DONE after the round using k_0; DONE -> IDLE on out_ready=1.
REQ-020 out_valid SHALL be high only in DONE, and pt SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Latency: out_valid SHALL rise 2*ROUNDS+1 cycles after the accept edge (65 for ROUNDS=32).
REQ-022 A transfer that completes in DONE SHALL return the core to IDLE, and in_ready SHALL rise on the next cycle; the core SHALL NOT accept in the same cycle as the transfer.
REQ-023 The core SHALL ignore in_valid in every state except IDLE.
REQ-024 A round counter SHALL count 0..ROUNDS-1 and SHALL wrap to 0 on each phase change.

Reset
REQ-025 While reset=1 the core SHALL enter IDLE with in_ready=1, out_valid=0, busy=0, pt=0 and round counter=0.
REQ-026 Reset asserted in EXPAND, DECRYPT or DONE SHALL abort the block without producing any output.
REQ-027 The key store contents SHALL NOT be reset and SHALL NOT be read before they are written.

Configuration
REQ-028 Macro SIMECK_KEY_CACHE_EN SHALL control key caching.
REQ-029 With SIMECK_KEY_CACHE_EN defined, the core SHALL keep the last expanded key and a valid flag (the flag cleared by reset).
REQ-030 With the macro defined, an accept with key equal to the cached key and the flag set SHALL skip EXPAND, giving latency ROUNDS+1 (33).
REQ-031 With the macro defined, reset SHALL clear the cache valid flag.
REQ-032 Without SIMECK_KEY_CACHE_EN, every block SHALL run EXPAND and no cache registers SHALL exist.

Structure
REQ-033 Package simeck_pkg SHALL hold WORD_W=16, ROUNDS_MAX=32, C_CONST=16'hFFFC, the f() function and the FSM state typedef {IDLE, EXPAND, DECRYPT, DONE}.
REQ-034 The key schedule (t-register shift, LFSR and key-store write) SHALL be a sub-module named simeck_keysched.
REQ-035 The datapath registers SHALL use the team's synchronous-reset register style.

Verification
REQ-036 key=64'h1918111009080100, ct=32'h770d2c76 -> pt=32'h65656877, with out_valid exactly 65 cycles after the accept edge.
REQ-037 Hold out_ready=0 for 10 cycles after out_valid -> pt and out_valid remain stable and in_ready stays 0; a transfer follows when out_ready=1.
REQ-038 Assert reset at cycle 40 after accept -> out_valid never rises, and in_ready=1 on the cycle after reset deasserts.
REQ-039 Pulse in_valid with new data during DECRYPT -> the data is ignored and the result matches the first block.
REQ-040 With SIMECK_KEY_CACHE_EN defined, two back-to-back blocks with the same key -> the second block has latency 33; a changed key -> latency 65.
REQ-041 Random key and plaintext, encrypted by a software reference model -> decryption returns the original plaintext for 1000 vectors.
